// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin share of one ALU between keypad and a UART command port; UART_ERR_EN enables 0xEE replies to bad frame headers.
module alu_share_ctrl #(
  parameter logic [7:0] HDR = 8'hA0,
  parameter int         W   = 9
) (
  input  logic         hwclk,
  input  logic         reset,
  input  logic         key_req,
  input  logic [W-1:0] key_op1,
  input  logic [W-1:0] key_op2,
  input  logic [2:0]   key_opcode,
  output logic         key_done,
  output logic [W-1:0] key_result,
  output logic [W-1:0] alu_op1,
  output logic [W-1:0] alu_op2,
  output logic [2:0]   alu_opcode,
  input  logic [W-1:0] alu_result,
  input  logic [7:0]   rxdata,
  input  logic         rxready,
  output logic         rxclk,
  output logic [7:0]   txdata,
  input  logic         txready,
  output logic         txclk
);
  typedef enum logic [2:0] {A_IDLE, A_EVAL_K, A_EVAL_U, A_DONE_K, A_DONE_U} arb_t;
  typedef enum logic [2:0] {U_RX_OP, U_RX_A, U_RX_B, U_WAIT, U_TX_HI, U_TX_LO, U_TX_ERR} uart_t;
  arb_t         arb_q, arb_d;
  uart_t        u_q, u_d;
  logic         last_u_q, last_u_d;
  logic [W-1:0] key_result_q, key_result_d;
  logic [W-1:0] ures_q, ures_d;
  logic [2:0]   opc_q, opc_d;
  logic [7:0]   b1_q, b1_d, b2_q, b2_d;
  logic         rxclk_q, rxclk_d;
  logic         uart_req, grant_k, rx_st, tx_st, pop, push, hdr_ok;
  always_ff @(posedge hwclk) begin
    if (reset) begin
      arb_q        <= A_IDLE;
      u_q          <= U_RX_OP;
      last_u_q     <= 1'b1;
      key_result_q <= '0;
      ures_q       <= '0;
      opc_q        <= '0;
      b1_q         <= '0;
      b2_q         <= '0;
      rxclk_q      <= 1'b0;
    end else begin
      arb_q        <= arb_d;
      u_q          <= u_d;
      last_u_q     <= last_u_d;
      key_result_q <= key_result_d;
      ures_q       <= ures_d;
      opc_q        <= opc_d;
      b1_q         <= b1_d;
      b2_q         <= b2_d;
      rxclk_q      <= rxclk_d;
    end
  end
  assign uart_req   = u_q == U_WAIT;
  // on a tie the keypad wins unless it was served last
  assign grant_k    = key_req && (!uart_req || last_u_q);
  assign key_done   = !reset && arb_q == A_DONE_K;
  assign key_result = key_result_q;
  always_comb begin
    arb_d        = arb_q;
    last_u_d     = last_u_q;
    key_result_d = key_result_q;
    ures_d       = ures_q;
    alu_op1      = '0;
    alu_op2      = '0;
    alu_opcode   = '0;
    case (arb_q)
      A_IDLE: arb_d = grant_k ? A_EVAL_K : uart_req ? A_EVAL_U : A_IDLE;
      A_EVAL_K: begin
        alu_op1      = key_op1;
        alu_op2      = key_op2;
        alu_opcode   = key_opcode;
        key_result_d = alu_result;
        last_u_d     = 1'b0;
        arb_d        = A_DONE_K;
      end
      A_EVAL_U: begin
        alu_op1    = {{(W-8){1'b0}}, b1_q};
        alu_op2    = {{(W-8){1'b0}}, b2_q};
        alu_opcode = opc_q;
        ures_d     = alu_result;
        last_u_d   = 1'b1;
        arb_d      = A_DONE_U;
      end
      default: arb_d = A_IDLE;
    endcase
  end
  assign rx_st   = u_q inside {U_RX_OP, U_RX_A, U_RX_B};
  assign tx_st   = u_q inside {U_TX_HI, U_TX_LO, U_TX_ERR};
  // the previous-cycle pop blocks a second back-to-back pop
  assign pop     = !reset && rx_st && rxready && !rxclk_q;
  assign push    = !reset && tx_st && txready;
  assign rxclk   = pop;
  assign rxclk_d = pop;
  assign txclk   = push;
  assign hdr_ok  = rxdata[7:3] == HDR[7:3];
  assign txdata  = !push ? 8'h00 : u_q == U_TX_HI ? 8'(ures_q >> 8) : u_q == U_TX_LO ? ures_q[7:0] : 8'hEE;
  always_comb begin
    u_d   = u_q;
    opc_d = opc_q;
    b1_d  = b1_q;
    b2_d  = b2_q;
    case (u_q)
      U_RX_OP: if (pop) begin
        opc_d = hdr_ok ? rxdata[2:0] : opc_q;
`ifdef UART_ERR_EN
        u_d   = hdr_ok ? U_RX_A : U_TX_ERR;
`else
        u_d   = hdr_ok ? U_RX_A : U_RX_OP;
`endif
      end
      U_RX_A: if (pop) begin
        b1_d = rxdata;
        u_d  = U_RX_B;
      end
      U_RX_B: if (pop) begin
        b2_d = rxdata;
        u_d  = U_WAIT;
      end
      U_WAIT:   u_d = arb_q == A_DONE_U ? U_TX_HI : U_WAIT;
      U_TX_HI:  u_d = push ? U_TX_LO : U_TX_HI;
      U_TX_LO:  u_d = push ? U_RX_OP : U_TX_LO;
      U_TX_ERR: u_d = push ? U_RX_OP : U_TX_ERR;
      default:  u_d = U_RX_OP;
    endcase
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of keypad/UART ALU sharing, framing, flow control and reset abort.
module tb_alu_share_ctrl;
  logic       hwclk = 0, reset = 1, key_req = 0, txready = 1;
  logic [8:0] key_op1 = 0, key_op2 = 0;
  logic [2:0] key_opcode = 0;
  logic       key_done, rxready, rxclk, txclk;
  logic [8:0] key_result, alu_op1, alu_op2, alu_result;
  logic [2:0] alu_opcode;
  logic [7:0] rxdata, txdata;
  logic [7:0] rxbuf [0:63];
  logic [7:0] txlog [0:63];
  logic [8:0] alu_log [0:63];
  int rx_wr = 0, rx_rd = 0, n_tx = 0, n_alu = 0, n_kd = 0, n_pop = 0, dbl = 0, txbad = 0;
  int n_tests = 0, n_fail = 0;
  logic rxclk_p = 0;
  alu_share_ctrl dut (
    .hwclk(hwclk), .reset(reset), .key_req(key_req), .key_op1(key_op1), .key_op2(key_op2),
    .key_opcode(key_opcode), .key_done(key_done), .key_result(key_result), .alu_op1(alu_op1),
    .alu_op2(alu_op2), .alu_opcode(alu_opcode), .alu_result(alu_result), .rxdata(rxdata),
    .rxready(rxready), .rxclk(rxclk), .txdata(txdata), .txready(txready), .txclk(txclk)
  );
  always #5 hwclk = ~hwclk;
  assign rxready = rx_rd != rx_wr;
  assign rxdata  = rxbuf[rx_rd[5:0]];
  always_comb
    alu_result = alu_opcode == 3'd0 ? alu_op1 + alu_op2 :
                 alu_opcode == 3'd1 ? alu_op1 - alu_op2 :
                 alu_opcode == 3'd2 ? alu_op1 & alu_op2 :
                 alu_opcode == 3'd3 ? alu_op1 | alu_op2 :
                 alu_opcode == 3'd4 ? alu_op1 ^ alu_op2 : 9'd0;
  always @(posedge hwclk) begin
    if (rxclk) begin
      rx_rd <= rx_rd + 1;
      n_pop <= n_pop + 1;
    end
    if (txclk) begin
      txlog[n_tx[5:0]] <= txdata;
      n_tx <= n_tx + 1;
      if (!txready) txbad <= txbad + 1;
    end
    if (alu_op1 != 0 || alu_op2 != 0 || alu_opcode != 0) begin
      alu_log[n_alu[5:0]] <= alu_op1;
      n_alu <= n_alu + 1;
    end
    if (key_done) n_kd <= n_kd + 1;
    if (rxclk && rxclk_p) dbl <= dbl + 1;
    rxclk_p <= rxclk;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] b);
    rxbuf[rx_wr[5:0]] = b;
    rx_wr++;
  endtask
  task automatic wait_tx(input int upto, input string tag);
    int c = 0;
    while (n_tx < upto && c < 200) begin
      @(posedge hwclk); #1;
      c++;
    end
    chk(tag, int'(n_tx >= upto), 1);
  endtask
  task automatic wait_pop(input int upto, input string tag);
    int c = 0;
    while (n_pop < upto && c < 200) begin
      @(posedge hwclk); #1;
      c++;
    end
    chk(tag, int'(n_pop >= upto), 1);
  endtask
  task automatic key_run(input logic [8:0] a, input logic [8:0] b, input logic [2:0] op, output int lat);
    key_op1 = a;
    key_op2 = b;
    key_opcode = op;
    key_req = 1;
    lat = 0;
    do begin
      @(posedge hwclk); #1;
      lat++;
    end while (!key_done && lat < 20);
    key_req = 0;
  endtask
  task automatic pulse_reset();
    reset = 1;
    @(posedge hwclk); #1;
    reset = 0;
  endtask
  initial begin
    int lat, b, bp, bt, bk;
    repeat (2) @(posedge hwclk);
    #1 reset = 0;
    @(negedge hwclk);
    chk("rst key_done", key_done, 0);
    chk("rst key_result", key_result, 0);
    chk("rst alu_op1", alu_op1, 0);
    chk("rst txclk", txclk, 0);
    chk("rst rxclk", rxclk, 0);
    chk("rst txdata", txdata, 0);
    @(posedge hwclk); #1;
    b = n_alu;
    key_run(9'd12, 9'd7, 3'd0, lat);
    chk("t1 latency", lat, 2);
    chk("t1 result", key_result, 19);
    @(posedge hwclk); #1;
    chk("t1 done drop", key_done, 0);
    chk("t1 alu_op1 quiet", alu_op1, 0);
    chk("t1 alu_op2 quiet", alu_op2, 0);
    chk("t1 alu evals", n_alu - b, 1);
    b = n_alu; bp = n_pop; bt = n_tx;
    push(8'hA0); push(8'h05); push(8'h03);
    wait_tx(bt + 2, "t2 tx timeout");
    chk("t2 tx hi", txlog[bt], 8'h00);
    chk("t2 tx lo", txlog[bt + 1], 8'h08);
    chk("t2 pops", n_pop - bp, 3);
    chk("t2 alu evals", n_alu - b, 1);
    chk("t2 alu op1", alu_log[b], 5);
    pulse_reset();
    b = n_alu; bp = n_pop; bt = n_tx;
    push(8'hA1); push(8'h14); push(8'h04);
    wait_pop(bp + 3, "t3 pop timeout");
    key_run(9'd3, 9'd4, 3'd0, lat);
    chk("t3 tie key latency", lat, 2);
    chk("t3 key result", key_result, 7);
    wait_tx(bt + 2, "t3 tx timeout");
    chk("t3 tx hi", txlog[bt], 8'h00);
    chk("t3 tx lo", txlog[bt + 1], 8'h10);
    chk("t3 first grant", alu_log[b], 3);
    chk("t3 second grant", alu_log[b + 1], 20);
    key_run(9'd2, 9'd2, 3'd0, lat);
    chk("t3 lone key latency", lat, 2);
    @(posedge hwclk); #1;
    b = n_alu; bp = n_pop; bt = n_tx;
    push(8'hA0); push(8'h06); push(8'h01);
    wait_pop(bp + 3, "t3b pop timeout");
    key_run(9'd5, 9'd1, 3'd1, lat);
    chk("t3b tie key latency", lat, 5);
    chk("t3b key result", key_result, 4);
    wait_tx(bt + 2, "t3b tx timeout");
    chk("t3b tx lo", txlog[bt + 1], 8'h07);
    chk("t3b first grant", alu_log[b], 6);
    chk("t3b second grant", alu_log[b + 1], 5);
    b = n_alu; bp = n_pop; bt = n_tx;
    push(8'h55); push(8'hA1); push(8'h09); push(8'h04);
`ifdef UART_ERR_EN
    wait_tx(bt + 3, "t4 tx timeout");
    chk("t4 err byte", txlog[bt], 8'hEE);
    chk("t4 tx hi", txlog[bt + 1], 8'h00);
    chk("t4 tx lo", txlog[bt + 2], 8'h05);
`else
    wait_tx(bt + 2, "t4 tx timeout");
    chk("t4 tx hi", txlog[bt], 8'h00);
    chk("t4 tx lo", txlog[bt + 1], 8'h05);
    repeat (4) @(posedge hwclk);
    #1 chk("t4 tx count", n_tx - bt, 2);
`endif
    chk("t4 pops", n_pop - bp, 4);
    chk("t4 alu evals", n_alu - b, 1);
    txready = 0;
    b = n_alu; bp = n_pop; bt = n_tx;
    push(8'hA0); push(8'h05); push(8'h03);
    wait_pop(bp + 3, "t5 pop timeout");
    repeat (10) @(posedge hwclk);
    #1 chk("t5 no tx while blocked", n_tx - bt, 0);
    chk("t5 alu evals", n_alu - b, 1);
    txready = 1;
    wait_tx(bt + 2, "t5 tx timeout");
    chk("t5 tx hi", txlog[bt], 8'h00);
    chk("t5 tx lo", txlog[bt + 1], 8'h08);
    bp = n_pop; bt = n_tx; bk = n_kd;
    push(8'hA0); push(8'h07); push(8'h02);
    wait_pop(bp + 3, "t6 pop timeout");
    @(posedge hwclk); #1;
    chk("t6 in eval_u", alu_op1, 7);
    pulse_reset();
    repeat (6) @(posedge hwclk);
    #1 chk("t6 no tx after abort", n_tx - bt, 0);
    chk("t6 no done after abort", n_kd - bk, 0);
    bp = n_pop;
    push(8'hA0); push(8'h09);
    wait_pop(bp + 2, "t6b pop timeout");
    pulse_reset();
    repeat (2) @(posedge hwclk);
    #1 bt = n_tx;
    push(8'hA2); push(8'h0F); push(8'h03);
    wait_tx(bt + 2, "t6b tx timeout");
    chk("t6b tx hi", txlog[bt], 8'h00);
    chk("t6b tx lo", txlog[bt + 1], 8'h03);
    chk("rxclk back-to-back", dbl, 0);
    chk("txclk without txready", txbad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
